// File: rtl/result_uart_tx.sv
// Converts a latched 64-bit result to decimal and sends it as 8N1 UART text ending in CR LF.
// Define RESULT_HEX_EN to append " 0x" and 16 lowercase hex digits before the CR LF.
//
// state   | meaning
// IDLE    | wait for done=1 with sent=0, latch total_sum
// CONVERT | 64 double-dabble shifts, one per cycle
// LOAD    | first cycle of a start bit, character loaded into the shifter
// SEND    | remainder of start bit, 8 data bits, stop bit
// FIN     | one cycle: busy drops, sent rises
module result_uart_tx #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] total_sum,
   input  logic        done,
   output logic        tx,
   output logic        busy,
   output logic        sent
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 2);
`ifdef RESULT_HEX_EN
   localparam logic [5:0] TAIL = 6'd21;
`else
   localparam logic [5:0] TAIL = 6'd2;
`endif

   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_LOAD, S_SEND, S_FIN} state_t;

   state_t          state_q, state_d;
   logic [63:0]     bin_q, bin_d;
   logic [79:0]     bcd_q, bcd_d;
   logic [5:0]      conv_q, conv_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [3:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [5:0]      idx_q, idx_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            sent_q, sent_d;
`ifdef RESULT_HEX_EN
   logic [63:0]     val_q, val_d;
   logic [3:0]      hpos;
`endif

   logic [75:0]     adj;
   logic [4:0]      ndig;
   logic [4:0]      dsel;
   logic [5:0]      tail_pos;
   logic [5:0]      last_idx;
   logic [7:0]      ch;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   // The top digit never reaches 5 before the final shift, so it skips the add-3 step.
   always_comb begin
      adj = '0;
      for (int i = 0; i < 19; i++) begin
         adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      end
   end

   always_comb begin
      ndig = 5'd1;
      for (int i = 1; i < 20; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) ndig = 5'(i + 1);
      end
   end

   assign last_idx = {1'b0, ndig} + TAIL - 6'd1;

   always_comb begin
      ch       = 8'h0D;
      tail_pos = idx_q - {1'b0, ndig};
      dsel     = ndig - 5'd1 - idx_q[4:0];
`ifdef RESULT_HEX_EN
      hpos     = 4'(6'd18 - tail_pos);
`endif
      if (idx_q < {1'b0, ndig}) begin
         ch = 8'h30 + {4'h0, bcd_q[{dsel, 2'b00} +: 4]};
      end
`ifdef RESULT_HEX_EN
      else if (tail_pos == 6'd0)  ch = 8'h20;
      else if (tail_pos == 6'd1)  ch = 8'h30;
      else if (tail_pos == 6'd2)  ch = 8'h78;
      else if (tail_pos <= 6'd18) ch = hex_ascii(val_q[{hpos, 2'b00} +: 4]);
      else if (tail_pos == 6'd19) ch = 8'h0D;
      else                        ch = 8'h0A;
`else
      else if (tail_pos == 6'd0)  ch = 8'h0D;
      else                        ch = 8'h0A;
`endif
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      conv_d  = conv_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      sent_d  = done ? sent_q : 1'b0;
`ifdef RESULT_HEX_EN
      val_d   = val_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (done && !sent_q) begin
               bin_d   = total_sum;
               bcd_d   = '0;
               conv_d  = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CONVERT;
`ifdef RESULT_HEX_EN
               val_d   = total_sum;
`endif
            end
         end
         S_CONVERT: begin
            bcd_d  = {bcd_q[78:76], adj, bin_q[63]};
            bin_d  = {bin_q[62:0], 1'b0};
            conv_d = conv_q + 6'd1;
            if (conv_q == 6'd63) begin
               tx_d    = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            shreg_d = ch;
            bit_d   = 4'd0;
            baud_d  = BAUD_LOAD;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else begin
               baud_d = BAUD_FULL;
               if (bit_q != 4'd9) begin
                  tx_d    = (bit_q == 4'd8) ? 1'b1 : shreg_q[0];
                  shreg_d = {1'b1, shreg_q[7:1]};
                  bit_d   = bit_q + 4'd1;
               end else if (idx_q == last_idx) begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  sent_d  = 1'b1;
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + 6'd1;
                  tx_d    = 1'b0;
                  state_d = S_LOAD;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         conv_q  <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         sent_q  <= 1'b0;
`ifdef RESULT_HEX_EN
         val_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         conv_q  <= conv_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         sent_q  <= sent_d;
`ifdef RESULT_HEX_EN
         val_q   <= val_d;
`endif
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign sent = sent_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a UART receiver decodes tx every cycle and reports are compared to
// strings built from the latched value by plain decimal/hex arithmetic.
module tb_result_uart_tx;
   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        done = 1'b0;
   logic [63:0] total_sum = '0;
   logic        tx, busy, sent;

   always #5 clk = ~clk;

   result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .total_sum(total_sum), .done(done),
      .tx(tx), .busy(busy), .sent(sent)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_q[$];
   int         rx_starts = 0;
   bit         rx_active = 0;
   int         rx_cnt = 0;
   logic [9:0] rx_bits = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic string vis(input string s);
      string r = "";
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h0D)      r = {r, "\\r"};
         else if (s[i] == 8'h0A) r = {r, "\\n"};
         else                    r = $sformatf("%s%c", r, s[i]);
      end
      return r;
   endfunction

   task automatic check_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=\"%s\" required=\"%s\"", name, vis(act), vis(exp));
      end
   endtask

   // Reference text of a report, straight from the value.
   function automatic string model_str(input logic [63:0] v);
      string      s = "";
      string      hd = "0123456789abcdef";
      logic [63:0] t = v;
      logic [7:0] c;
      do begin
         c = 8'h30 + 8'(t % 64'd10);
         s = $sformatf("%c%s", c, s);
         t = t / 64'd10;
      end while (t != 0);
`ifdef RESULT_HEX_EN
      s = {s, " 0x"};
      for (int i = 15; i >= 0; i--) begin
         int n = int'((v >> (4 * i)) & 64'hF);
         s = {s, hd.substr(n, n)};
      end
`endif
      return {s, "\r\n"};
   endfunction

   function automatic string lit(input string d, input string h);
`ifdef RESULT_HEX_EN
      return {d, " 0x", h, "\r\n"};
`else
      return (h.len() >= 0) ? {d, "\r\n"} : "";
`endif
   endfunction

   // One clock of observation: UART receiver plus idle-line check.
   task automatic tick();
      int j;
      @(negedge clk);
      if (rst) begin
         rx_active = 0;
         return;
      end
      if (!busy) check("idle_tx", tx, 1);
      if (!rx_active && tx == 1'b0) begin
         rx_active = 1;
         rx_cnt    = 0;
         rx_starts++;
      end
      if (rx_active) begin
         j = rx_cnt / CPB;
         if (rx_cnt % CPB == 0) rx_bits[j] = tx;
         else check("bit_hold", tx, rx_bits[j]);
         if (rx_cnt == 10 * CPB - 1) begin
            check("stop_bit", rx_bits[9], 1);
            rx_q.push_back(rx_bits[8:1]);
            rx_active = 0;
         end
         rx_cnt++;
      end
   endtask

   task automatic do_report(input logic [63:0] v, input string exp_s, input bit scramble);
      int    base = rx_q.size();
      int    t = 0;
      int    cnt = 0;
      int    lo;
      string r = "";
      total_sum = v;
      done      = 1'b1;
      tick();
      while (!busy && t < 10) begin
         tick();
         t++;
      end
      check("busy_start", busy, 1);
      while (busy && cnt < 5000) begin
         cnt++;
         if (scramble) begin
            total_sum = {$urandom, $urandom};
            done = (cnt < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         tick();
      end
      lo = 64 + 10 * CPB * exp_s.len();
      checks++;
      if (cnt < lo || cnt > lo + 2) begin
         errors++;
         $display("FAIL busy_len actual=%0d required=%0d..%0d", cnt, lo, lo + 2);
      end
      check("sent_after", sent, 1);
      tick();
      tick();
      for (int i = base; i < rx_q.size(); i++) r = $sformatf("%s%c", r, rx_q[i]);
      check_str("report_text", r, exp_s);
   endtask

   task automatic drop_done();
      done = 1'b0;
      tick();
      check("sent_clear", sent, 0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      int          base, b, t;

      repeat (3) tick();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_sent", sent, 0);
      rst = 1'b0;
      tick();

      check_str("model_pin", model_str(64'd32976912643), lit("32976912643", "00000007ad93c103"));
      do_report(64'd32976912643, lit("32976912643", "00000007ad93c103"), 0);
      drop_done();
      do_report(64'd0, lit("0", "0000000000000000"), 0);
      drop_done();
      do_report(64'hFFFF_FFFF_FFFF_FFFF, lit("18446744073709551615", "ffffffffffffffff"), 0);

      base = rx_starts;
      b = 0;
      repeat (10000) begin
         tick();
         if (busy) b++;
      end
      check("hold_no_busy", 64'(b), 0);
      check("hold_no_start", 64'(rx_starts - base), 0);
      check("hold_sent", sent, 1);
      drop_done();
      do_report(64'd7, lit("7", "0000000000000007"), 0);
      drop_done();

      for (int k = 0; k < 8; k++) begin
         v = {$urandom, $urandom} >> $urandom_range(0, 63);
         do_report(v, model_str(v), 1);
         drop_done();
      end

      v = {$urandom, $urandom};
      total_sum = v;
      done = 1'b1;
      base = rx_starts;
      t = 0;
      while (rx_starts - base < 3 && t < 3000) begin
         tick();
         t++;
      end
      check("third_char_seen", 64'(rx_starts - base), 3);
      repeat (2 * CPB + 2) tick();
      rst = 1'b1;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_sent", sent, 0);
      tick();
      tick();
      rst = 1'b0;
      do_report(v, model_str(v), 0);
      drop_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per UART bit (115200 baud at 25 MHz); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port total_sum, input, 64, unsigned result from the solver; sampled only at trigger.
REQ-005 SHALL have port done, input, 1, solver completion level; trigger source.
REQ-006 SHALL have port tx, output, 1, UART serial line, 8N1, idle high.
REQ-007 SHALL have port busy, output, 1, high from trigger until the last stop bit completes.
REQ-008 SHALL have port sent, output, 1, high after a full report is transmitted; cleared when done falls.

Function
REQ-009 SHALL trigger when done=1 while in IDLE with sent=0; total_sum latched on the trigger edge; later total_sum changes ignored.
REQ-010 SHALL use states IDLE -> CONVERT -> LOAD -> SEND -> (LOAD | FIN) -> FIN -> IDLE.
REQ-011 CONVERT SHALL do 64-bit binary-to-BCD (double dabble, 20 digits), one shift per cycle, exactly 64 cycles, then enter LOAD.
REQ-012 SHALL send decimal digits MSB first with leading zeros suppressed; value 0 sends single "0"; max 20 digits.
REQ-013 SHALL terminate every report with CR (0x0D) then LF (0x0A).
REQ-014 Each character SHALL be framed as start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-015 Characters SHALL be back-to-back: next start bit begins the cycle after previous stop bit ends (LOAD adds no extra tx cycle).
REQ-016 tx SHALL be 1 in IDLE, CONVERT and FIN.
REQ-017 FIN SHALL last one cycle: busy deasserts, sent asserts.
REQ-018 done falling at any time SHALL clear sent next cycle; done activity during busy SHALL NOT restart or abort a report.
REQ-019 done held high after sent SHALL NOT retransmit; a new report requires done low then high.
REQ-020 Baud counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap error.

Reset
REQ-021 Asserting rst SHALL immediately force tx=1, busy=0, sent=0, state IDLE, counters and BCD register zero, including mid-frame.
REQ-022 After rst release with done already high, SHALL trigger on the first clock edge (report sent again).

Configuration
REQ-023 Macro RESULT_HEX_EN defined: after the decimal digits and before CR LF, SHALL send space, "0x", then exactly 16 lowercase hex digits of the latched value, MSB first, zero-padded.
REQ-024 Macro RESULT_HEX_EN undefined: SHALL send decimal digits then CR LF only; no hex logic synthesized.

Verification
REQ-025 total_sum=32976912643, done rises, CLKS_PER_BIT=4 -> tx decodes "32976912643\r\n" (13 chars); busy lasts 1+64+13*40 cycles ±1; sent=1 after.
REQ-026 total_sum=0 -> "0\r\n"; total_sum=2^64-1 -> "18446744073709551615\r\n".
REQ-027 done held high 10000 cycles after sent -> no further start bit; drop done then raise with total_sum=7 -> "7\r\n".
REQ-028 rst pulsed during 3rd character data bits -> tx=1 and busy=0 same cycle as rst, no glitch; with done high after release, full report resent.
REQ-029 RESULT_HEX_EN defined, total_sum=32976912643 -> "32976912643 0x00000007ad93c103\r\n".
REQ-030 total_sum changed during CONVERT and SEND -> output unchanged from value latched at trigger.
